lif_stdp_chain: RTL and testbench

//  Parametrised successor of the two-neuron LIF/STDP core: a feed-forward chain of N_NEURONS

---
 rtl/lif_stdp_chain_if.sv | 40 ++++
 rtl/lif_stdp_chain.sv | 145 ++++++++++++++
 tb/tb_lif_stdp_chain.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lif_stdp_chain_if.sv
// lif_stdp_chain_if
//  Signal bundle between the chain core and whatever drives it (the tt_um
//  wrapper, or a testbench).
//  Parameters: N_NEURONS (chain length), V_W (membrane width), W_W (weight width).
//  Signals:
//    ena        1 = the core advances one update on this clk edge
//    i_in       8-bit input current to neuron 0
//    teach_i    per-neuron forced spike for this update
//    learn_en   1 = STDP weight updates enabled
//    probe_sel  neuron/synapse index for the probes
//    spike_o    registered spike vector (one-cycle pulses)
//    v_probe    membrane of neuron probe_sel (0 when out of range)
//    w_probe    weight of synapse probe_sel (0 when out of range)
//  Handshake: there is no valid/ready pair. ena is the only qualifier, and
//  every posedge with ena=1 is exactly one update. The master drives the
//  inputs and the slave (the core) drives spike_o and the probes.
interface lif_stdp_chain_if #(
  parameter int N_NEURONS = 4,
  parameter int V_W       = 8,
  parameter int W_W       = 6
);
  logic                 ena;
  logic [7:0]           i_in;
  logic [N_NEURONS-1:0] teach_i;
  logic                 learn_en;
  logic [2:0]           probe_sel;
  logic [N_NEURONS-1:0] spike_o;
  logic [V_W-1:0]       v_probe;
  logic [W_W-1:0]       w_probe;

  modport master (
    output ena, i_in, teach_i, learn_en, probe_sel,
    input  spike_o, v_probe, w_probe
  );

  modport slave (
    input  ena, i_in, teach_i, learn_en, probe_sel,
    output spike_o, v_probe, w_probe
  );
endinterface

// File: rtl/lif_stdp_chain.sv
// lif_stdp_chain
//  Feed-forward chain of N_NEURONS leaky integrate-and-fire neurons. Neuron 0
//  integrates the external current; neuron k integrates w[k-1] whenever
//  neuron k-1 spiked on the previous update. Each of the N_NEURONS-1
//  synapses learns online by pair-based STDP using 4-bit counter traces.
//  teach_i forces spikes for supervised training.
//  Ports:
//    clk    clock
//    rst_n  asynchronous active-low reset
//    bus    lif_stdp_chain_if.slave (ena, i_in, teach_i, learn_en, probe_sel
//           in; spike_o, v_probe, w_probe out)
//  Optional feature macro: LIF_REFRACTORY_EN. When defined, a neuron that
//  spikes holds v=0 and ignores its input and teacher for REFRAC_CYC updates.
//  There is no FSM; all state is the membrane, spike, trace, weight (and
//  optionally refractory) registers, all visible through spike_o and probes.
module lif_stdp_chain #(
  parameter int N_NEURONS  = 4,
  parameter int V_W        = 8,
  parameter int W_W        = 6,
  parameter int THRESH     = 200,
  parameter int LEAK_SHIFT = 3,
  parameter int TRACE_WIN  = 8,
  parameter int W_INIT     = 16,
  parameter int REFRAC_CYC = 4
) (
  input logic            clk,
  input logic            rst_n,
  lif_stdp_chain_if.slave bus
);

  localparam int NS = N_NEURONS - 1;
  // Sum width: wide enough for a full membrane plus the 8-bit input current
  // with a carry bit, so saturation can be detected before truncation.
  localparam int CW = ((V_W > 8) ? V_W : 8) + 1;

  if (N_NEURONS < 2 || N_NEURONS > 8 || TRACE_WIN < 1 || TRACE_WIN > 15 ||
      REFRAC_CYC < 0 || REFRAC_CYC > 15) begin : g_bad_param
    $error("lif_stdp_chain: parameter out of range");
  end

  logic [V_W-1:0]       v_q     [N_NEURONS];
  logic [N_NEURONS-1:0] spike_q;
  logic [3:0]           tr_q    [N_NEURONS];
  logic [W_W-1:0]       w_q     [NS];

  logic [CW-1:0]        x_ext   [N_NEURONS];
  logic [CW-1:0]        sum     [N_NEURONS];
  logic [V_W-1:0]       v_next  [N_NEURONS];
  logic [N_NEURONS-1:0] fire;
  logic [NS-1:0]        ltp;
  logic [NS-1:0]        ltd;
  logic [W_W-1:0]       w_next  [NS];
  logic [V_W-1:0]       v_probe_c;
  logic [W_W-1:0]       w_probe_c;

`ifdef LIF_REFRACTORY_EN
  logic [3:0]           rc_q    [N_NEURONS];
`endif

  // Neuron update, all neurons in parallel from the old register values.
  always_comb begin
    fire     = '0;
    x_ext[0] = CW'(bus.i_in);
    for (int k = 1; k < N_NEURONS; k++) begin
      x_ext[k] = spike_q[k-1] ? CW'(w_q[k-1]) : '0;
    end
    for (int k = 0; k < N_NEURONS; k++) begin
      sum[k]    = CW'(v_q[k]) - CW'(v_q[k] >> LEAK_SHIFT) + x_ext[k];
      v_next[k] = (sum[k][CW-1:V_W] != '0) ? {V_W{1'b1}} : sum[k][V_W-1:0];
      fire[k]   = (v_next[k] >= V_W'(THRESH)) | bus.teach_i[k];
`ifdef LIF_REFRACTORY_EN
      // A refractory neuron neither fires nor accepts a teacher spike.
      if (rc_q[k] != 4'd0) fire[k] = 1'b0;
`endif
    end
  end

  // STDP: old traces against the spikes of this update. LTD requires the
  // post neuron to be silent, so a simultaneous pre/post pair never moves w.
  always_comb begin
    ltp = '0;
    ltd = '0;
    for (int j = 0; j < NS; j++) begin
      ltp[j]    = fire[j+1] & (tr_q[j] != 4'd0);
      ltd[j]    = fire[j] & (tr_q[j+1] != 4'd0) & ~fire[j+1];
      w_next[j] = w_q[j];
      if (bus.learn_en) begin
        if (ltp[j] && !ltd[j] && (w_q[j] != {W_W{1'b1}})) begin
          w_next[j] = w_q[j] + 1'b1;
        end else if (ltd[j] && !ltp[j] && (w_q[j] != '0)) begin
          w_next[j] = w_q[j] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k]  <= '0;
        tr_q[k] <= 4'd0;
`ifdef LIF_REFRACTORY_EN
        rc_q[k] <= 4'd0;
`endif
      end
      for (int j = 0; j < NS; j++) begin
        w_q[j] <= W_W'(W_INIT);
      end
    end else if (bus.ena) begin
      spike_q <= fire;
      for (int k = 0; k < N_NEURONS; k++) begin
`ifdef LIF_REFRACTORY_EN
        v_q[k] <= (fire[k] || (rc_q[k] != 4'd0)) ? '0 : v_next[k];
        if (fire[k])                rc_q[k] <= 4'(REFRAC_CYC);
        else if (rc_q[k] != 4'd0)   rc_q[k] <= rc_q[k] - 4'd1;
`else
        v_q[k] <= fire[k] ? '0 : v_next[k];
`endif
        if (fire[k])               tr_q[k] <= 4'(TRACE_WIN);
        else if (tr_q[k] != 4'd0)  tr_q[k] <= tr_q[k] - 4'd1;
      end
      for (int j = 0; j < NS; j++) begin
        w_q[j] <= w_next[j];
      end
    end
  end

  // Probes: combinational read of the selected register, 0 when out of range.
  always_comb begin
    v_probe_c = '0;
    w_probe_c = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (bus.probe_sel == 3'(k)) v_probe_c = v_q[k];
    end
    for (int j = 0; j < NS; j++) begin
      if (bus.probe_sel == 3'(j)) w_probe_c = w_q[j];
    end
  end

  assign bus.spike_o = spike_q;
  assign bus.v_probe = v_probe_c;
  assign bus.w_probe = w_probe_c;

endmodule

// File: tb/tb_lif_stdp_chain.sv
// tb_lif_stdp_chain
//  Directed bench for lif_stdp_chain (N_NEURONS=4, default parameters).
//  Inputs change 1 ns after a rising edge; outputs are read there too.
module tb_lif_stdp_chain;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  lif_stdp_chain_if #(.N_NEURONS(4), .V_W(8), .W_W(6)) bus ();

  lif_stdp_chain #(
    .N_NEURONS(4), .V_W(8), .W_W(6), .THRESH(200), .LEAK_SHIFT(3),
    .TRACE_WIN(8), .W_INIT(16), .REFRAC_CYC(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic [2:0] sel);
    bus.probe_sel = sel;
    #1;
  endtask

  // Called just after an edge: pulse reset well clear of the next edge.
  task automatic do_reset();
    bus.teach_i  = 4'b0000;
    bus.i_in     = 8'd0;
    bus.learn_en = 1'b0;
    bus.ena      = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [9:0] pat;
  logic [9:0] exp_pat;
  logic       spiked;

  initial begin
    bus.ena       = 1'b1;
    bus.i_in      = 8'd0;
    bus.teach_i   = 4'b0000;
    bus.learn_en  = 1'b0;
    bus.probe_sel = 3'd0;

    // ---- reset state (before any clock edge) ----
    #1 rst_n = 1'b0;
    #1;
    check("rst_spike", bus.spike_o, 4'b0000);
    check("rst_v0",    bus.v_probe, 0);
    check("rst_w0",    bus.w_probe, 16);
    probe(1); check("rst_w1", bus.w_probe, 16);
    probe(2); check("rst_w2", bus.w_probe, 16);
    probe(3); check("rst_w_out_of_range", bus.w_probe, 0);
    #1 rst_n = 1'b1;

    // ---- firing: i_in=255 from reset ----
    bus.i_in      = 8'd255;
    bus.probe_sel = 3'd1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      pat[i] = bus.spike_o[0];
`ifndef LIF_REFRACTORY_EN
      if (i == 1) check("fire_v1_edge2", bus.v_probe, 16);
      if (i == 2) check("fire_v1_edge3", bus.v_probe, 30);
`endif
    end
`ifdef LIF_REFRACTORY_EN
    exp_pat = 10'b0000100001;
`else
    exp_pat = 10'b1111111111;
`endif
    check("fire_pattern", pat, exp_pat);

    // ---- sub-threshold: i_in=20 for 200 updates ----
    do_reset();
    bus.i_in = 8'd20;
    spiked = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (bus.spike_o[0]) spiked = 1'b1;
    end
    check("sub_no_spike", spiked, 0);
    probe(0);
    check("sub_v_settled", (bus.v_probe >= 8'd160) && (bus.v_probe <= 8'd167), 1);

    // ---- LTP: pre at edge A, post forced at edge C ----
    do_reset();
    bus.learn_en = 1'b1;
    bus.teach_i = 4'b0001; step(1);
    bus.teach_i = 4'b0000; step(1);
    bus.teach_i = 4'b0010; step(1);
    bus.teach_i = 4'b0000;
    probe(0); check("ltp_w0", bus.w_probe, 17);
    probe(1); check("ltp_w1", bus.w_probe, 16);

    // ---- asynchronous reset mid-run ----
    bus.learn_en = 1'b0;
    bus.i_in = 8'd255;
    step(3);
    check("pre_rst_v1",    bus.v_probe, 32);
    check("pre_rst_spike", bus.spike_o, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("mid_rst_spike", bus.spike_o, 4'b0000);
    check("mid_rst_v1",    bus.v_probe, 0);
    probe(0); check("mid_rst_w0", bus.w_probe, 16);
    probe(1); check("mid_rst_w1", bus.w_probe, 16);
    probe(2); check("mid_rst_w2", bus.w_probe, 16);
    bus.i_in = 8'd0;
    rst_n = 1'b1;

    // ---- LTD: post first, then pre ----
    step(1);
    do_reset();
    bus.learn_en = 1'b1;
    bus.teach_i = 4'b0010; step(1);
    bus.teach_i = 4'b0001; step(1);
    bus.teach_i = 4'b0000;
    probe(0); check("ltd_w0", bus.w_probe, 15);

    // ---- same pattern with learning disabled ----
    do_reset();
    bus.learn_en = 1'b0;
    bus.teach_i = 4'b0010; step(1);
    bus.teach_i = 4'b0001; step(1);
    bus.teach_i = 4'b0000;
    probe(0); check("ltd_nolearn_w0", bus.w_probe, 16);

    // ---- saturation: 70 isolated LTP pairs ----
    do_reset();
    bus.learn_en = 1'b1;
    for (int p = 0; p < 70; p++) begin
      bus.teach_i = 4'b0001; step(1);
      bus.teach_i = 4'b0010; step(1);
      bus.teach_i = 4'b0000; step(10);
      if (p == 45) begin
        probe(0); check("sat_w0_62", bus.w_probe, 62);
      end
    end
    probe(0); check("sat_w0_63", bus.w_probe, 63);

    // ---- build a known state, then freeze ----
    bus.teach_i = 4'b1111; step(1);
    bus.teach_i = 4'b0000;
    bus.i_in    = 8'd100;  step(1);
    bus.ena      = 1'b0;
    bus.i_in     = 8'd255;
    bus.teach_i  = 4'b1111;
    step(20);
    check("frz_spike", bus.spike_o, 4'b0000);
    probe(0); check("frz_v0", bus.v_probe, 100);
    probe(1); check("frz_v1", bus.v_probe, 63);
    probe(2); check("frz_v2", bus.v_probe, 16);
    probe(3); check("frz_v3", bus.v_probe, 16);
    probe(0); check("frz_w0", bus.w_probe, 63);
    probe(1); check("frz_w1", bus.w_probe, 16);
    probe(2); check("frz_w2", bus.w_probe, 16);

    // ---- resume: one leak-only update from the frozen state ----
    bus.ena     = 1'b1;
    bus.i_in    = 8'd0;
    bus.teach_i = 4'b0000;
    step(1);
    check("resume_spike", bus.spike_o, 4'b0000);
    probe(0); check("resume_v0", bus.v_probe, 88);
    probe(1); check("resume_v1", bus.v_probe, 56);
    probe(2); check("resume_v2", bus.v_probe, 14);

    // ---- final report ----
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
